// File: rtl/uc_multiciclo.sv
// Multicycle control unit for a small RV32 subset (load, store, R-type, addi, branch).
// Optional build macro: UC_X0_PROTECT_EN -- suppresses the register-file write in WB
// when the latched destination register is x0.
module uc_multiciclo (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic        flag,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        reg_we,
  output logic        mem_we,
  output logic        mux1_sel,
  output logic        mux2_sel,
  output logic [1:0]  alu_op,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_ADDI   = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0]       F7_SUB    = 7'b0100000;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_CMP  = 2'b10;
  localparam logic [1:0] ALU_IDLE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_BRANCH = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic              illegal_q, illegal_d;
  logic [XLEN-1:0]   instret_q, instret_d;

  logic [OPC_W-1:0]  opcode;
  logic [6:0]        funct7;
  logic              is_load;
  logic              is_store;
  logic              is_rtype;
  logic              wb_reg_we;

  // Field decode of the latched instruction word
  assign opcode   = ir_q[6:0];
  assign funct7   = ir_q[31:25];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_rtype = (opcode == OP_RTYPE);

`ifdef UC_X0_PROTECT_EN
  // Writes to x0 are dropped; the PC and retire count still advance
  assign wb_reg_we = (ir_q[11:7] != 5'd0);
  logic unused_ir;
  assign unused_ir = ^ir_q[24:12];
`else
  // Every writeback asserts the write enable, x0 included
  assign wb_reg_we = 1'b1;
  logic unused_ir;
  assign unused_ir = ^{ir_q[24:12], ir_q[11:7]};
`endif

  // State, instruction latch, sticky illegal flag and retire counter
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and Moore-style control decode (pc_src follows flag in BRANCH)
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    mux1_sel  = 1'b0;
    mux2_sel  = 1'b0;
    alu_op    = ALU_ADD;

    case (state_q)
      S_IDLE: begin
        alu_op = ALU_IDLE;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_we   = 1'b1;
        ir_d    = instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ADDI: state_d = S_EXEC;
          OP_BRANCH:                            state_d = S_BRANCH;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        mux1_sel = is_rtype;
        alu_op   = (is_rtype && (funct7 == F7_SUB)) ? ALU_SUB : ALU_ADD;
        state_d  = (is_load || is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (is_store) begin
          mem_we  = 1'b1;
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_we   = wb_reg_we;
        pc_we    = 1'b1;
        mux2_sel = !is_load;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alu_op  = ALU_CMP;
        pc_we   = 1'b1;
        pc_src  = flag;
        state_d = S_FETCH;
      end
      S_HALT: begin
        alu_op    = ALU_IDLE;
        illegal_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    instret_d = instret_q + XLEN'(pc_we);
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Scoreboard bench for uc_multiciclo: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_uc_multiciclo;

  logic        clock;
  logic        rst_n;
  logic        start;
  logic [31:0] instr;
  logic        flag;
  logic        ir_we, pc_we, pc_src, reg_we, mem_we, mux1_sel, mux2_sel;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] instret;

  uc_multiciclo dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .start    (start),
    .instr    (instr),
    .flag     (flag),
    .ir_we    (ir_we),
    .pc_we    (pc_we),
    .pc_src   (pc_src),
    .reg_we   (reg_we),
    .mem_we   (mem_we),
    .mux1_sel (mux1_sel),
    .mux2_sel (mux2_sel),
    .alu_op   (alu_op),
    .state    (state),
    .illegal  (illegal),
    .instret  (instret)
  );

  localparam logic [31:0] I_ADD   = 32'h0020_8033;
  localparam logic [31:0] I_SUB   = 32'h4020_8033;
  localparam logic [31:0] I_LOAD  = 32'h0051_2083;
  localparam logic [31:0] I_STORE = 32'h0011_2223;
  localparam logic [31:0] I_BEQ   = 32'h0020_8463;
  localparam logic [31:0] I_ADDI  = 32'h0050_0093;
  localparam logic [31:0] I_BAD   = 32'h0000_007F;

`ifdef UC_X0_PROTECT_EN
  localparam logic RG_X0 = 1'b0;
`else
  localparam logic RG_X0 = 1'b1;
`endif

  // enable bit order: {ir_we, pc_we, pc_src, reg_we, mem_we, mux1_sel, mux2_sel}
  localparam logic [6:0] EN_NONE  = 7'b0000000;
  localparam logic [6:0] EN_FETCH = 7'b1000000;
  localparam logic [6:0] EN_EXR   = 7'b0000010;
  localparam logic [6:0] EN_ST    = 7'b0100100;
  localparam logic [6:0] EN_BR1   = 7'b0110000;
  localparam logic [6:0] EN_BR0   = 7'b0100000;

  typedef struct {
    string       tag;
    logic [44:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [44:0] mk(input logic [2:0] st, input logic [6:0] en,
                                     input logic [1:0] alu, input logic ill,
                                     input logic [31:0] ret);
    mk = {st, en, alu, ill, ret};
  endfunction

  function automatic logic [6:0] en_wb(input logic rg, input logic m2);
    en_wb = {1'b0, 1'b1, 1'b0, rg, 1'b0, 1'b0, m2};
  endfunction

  task automatic push(input string tag, input logic [44:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, want);
    end
  endtask

  // Reset for one cycle; the reset record covers the cycle in which rst_n is low
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    flag  = 1'b0;
    instr = '0;
    push("reset", mk(3'd0, EN_NONE, 2'b11, 1'b0, 32'd0));
    wait_cycles(1);
    rst_n = 1'b1;
  endtask

  // Monitor: compare the full output vector once per cycle while expectations are pending
  always @(negedge clock) begin
    logic [44:0] obs;
    exp_t        e;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      obs = {state, ir_we, pc_we, pc_src, reg_we, mem_we, mux1_sel, mux2_sel,
             alu_op, illegal, instret};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got st=%0d en=%b alu=%b ill=%b ret=%h want st=%0d en=%b alu=%b ill=%b ret=%h",
                 e.tag, obs[44:42], obs[41:35], obs[34:33], obs[32], obs[31:0],
                 e.v[44:42], e.v[41:35], e.v[34:33], e.v[32], e.v[31:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    flag  = 1'b0;
    instr = '0;
    @(posedge clock);
    #1;
    do_reset();

    // add x0 with flag high and start held: flag and start must not matter
    start = 1'b1; instr = I_ADD; flag = 1'b1;
    push("add.idle", mk(3'd0, EN_NONE, 2'b11, 1'b0, 32'd0));
    wait_cycles(1);
    push("add.fetch", mk(3'd1, EN_FETCH, 2'b00, 1'b0, 32'd0));
    push("add.dec",   mk(3'd2, EN_NONE,  2'b00, 1'b0, 32'd0));
    push("add.exec",  mk(3'd3, EN_EXR,   2'b00, 1'b0, 32'd0));
    push("add.wb",    mk(3'd5, en_wb(RG_X0, 1'b1), 2'b00, 1'b0, 32'd0));
    wait_cycles(4);
    start = 1'b0;

    // sub x0
    instr = I_SUB; flag = 1'b0;
    push("sub.fetch", mk(3'd1, EN_FETCH, 2'b00, 1'b0, 32'd1));
    push("sub.dec",   mk(3'd2, EN_NONE,  2'b00, 1'b0, 32'd1));
    push("sub.exec",  mk(3'd3, EN_EXR,   2'b01, 1'b0, 32'd1));
    push("sub.wb",    mk(3'd5, en_wb(RG_X0, 1'b1), 2'b00, 1'b0, 32'd1));
    wait_cycles(4);

    // load x1: five cycles, memory dout written back
    instr = I_LOAD;
    push("ld.fetch", mk(3'd1, EN_FETCH, 2'b00, 1'b0, 32'd2));
    push("ld.dec",   mk(3'd2, EN_NONE,  2'b00, 1'b0, 32'd2));
    push("ld.exec",  mk(3'd3, EN_NONE,  2'b00, 1'b0, 32'd2));
    push("ld.mem",   mk(3'd4, EN_NONE,  2'b00, 1'b0, 32'd2));
    push("ld.wb",    mk(3'd5, en_wb(1'b1, 1'b0), 2'b00, 1'b0, 32'd2));
    wait_cycles(5);

    // store: single mem_we cycle that also advances the PC
    instr = I_STORE;
    push("st.fetch", mk(3'd1, EN_FETCH, 2'b00, 1'b0, 32'd3));
    push("st.dec",   mk(3'd2, EN_NONE,  2'b00, 1'b0, 32'd3));
    push("st.exec",  mk(3'd3, EN_NONE,  2'b00, 1'b0, 32'd3));
    push("st.mem",   mk(3'd4, EN_ST,    2'b00, 1'b0, 32'd3));
    wait_cycles(4);

    // beq taken
    instr = I_BEQ; flag = 1'b1;
    push("beq1.fetch", mk(3'd1, EN_FETCH, 2'b00, 1'b0, 32'd4));
    push("beq1.dec",   mk(3'd2, EN_NONE,  2'b00, 1'b0, 32'd4));
    push("beq1.br",    mk(3'd6, EN_BR1,   2'b10, 1'b0, 32'd4));
    wait_cycles(3);

    // beq not taken
    flag = 1'b0;
    push("beq0.fetch", mk(3'd1, EN_FETCH, 2'b00, 1'b0, 32'd5));
    push("beq0.dec",   mk(3'd2, EN_NONE,  2'b00, 1'b0, 32'd5));
    push("beq0.br",    mk(3'd6, EN_BR0,   2'b10, 1'b0, 32'd5));
    wait_cycles(3);

    // unsupported opcode: HALT is absorbing, start pulses ignored
    instr = I_BAD;
    push("bad.fetch", mk(3'd1, EN_FETCH, 2'b00, 1'b0, 32'd6));
    push("bad.dec",   mk(3'd2, EN_NONE,  2'b00, 1'b0, 32'd6));
    for (int i = 0; i < 4; i++)
      push($sformatf("halt%0d", i), mk(3'd7, EN_NONE, 2'b11, 1'b1, 32'd6));
    wait_cycles(3);
    start = 1'b1; wait_cycles(1);
    start = 1'b0; wait_cycles(1);
    start = 1'b1; wait_cycles(1);
    start = 1'b0;
    do_reset();

    // retire counter wrap: preload all-ones, retire one addi
    force dut.instret_q = 32'hFFFF_FFFF;
    push("wrap.pre", mk(3'd0, EN_NONE, 2'b11, 1'b0, 32'hFFFF_FFFF));
    wait_cycles(1);
    release dut.instret_q;
    start = 1'b1;
    push("wrap.idle", mk(3'd0, EN_NONE, 2'b11, 1'b0, 32'hFFFF_FFFF));
    wait_cycles(1);
    start = 1'b0; instr = I_ADDI;
    push("addi.fetch", mk(3'd1, EN_FETCH, 2'b00, 1'b0, 32'hFFFF_FFFF));
    push("addi.dec",   mk(3'd2, EN_NONE,  2'b00, 1'b0, 32'hFFFF_FFFF));
    push("addi.exec",  mk(3'd3, EN_NONE,  2'b00, 1'b0, 32'hFFFF_FFFF));
    push("addi.wb",    mk(3'd5, en_wb(1'b1, 1'b1), 2'b00, 1'b0, 32'hFFFF_FFFF));
    wait_cycles(4);
    check("wrap.instret", instret, 32'd0);

    // reset asserted in the middle of a store's MEM cycle
    instr = I_STORE;
    push("st2.fetch", mk(3'd1, EN_FETCH, 2'b00, 1'b0, 32'd0));
    push("st2.dec",   mk(3'd2, EN_NONE,  2'b00, 1'b0, 32'd0));
    push("st2.exec",  mk(3'd3, EN_NONE,  2'b00, 1'b0, 32'd0));
    wait_cycles(3);
    check("st2.mem_we_pre", {31'd0, mem_we}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.mem_we", {31'd0, mem_we}, 32'd0);
    check("midrst.pc_we",  {31'd0, pc_we},  32'd0);
    check("midrst.state",  {29'd0, state},  32'd0);
    push("midrst", mk(3'd0, EN_NONE, 2'b11, 1'b0, 32'd0));
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    push("post.idle", mk(3'd0, EN_NONE, 2'b11, 1'b0, 32'd0));
    wait_cycles(2);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
